apb4_crc_prog: RTL and testbench

APB4_CRC_PROG -- requirements
Module: apb4_crc_prog

---
 rtl/apb4_crc_prog.sv | 221 ++++++++++++++++++++++
 tb/tb_apb4_crc_prog.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_crc_prog.sv
// apb4_crc_prog: APB4 programmable CRC engine (8/16/32-bit) with an input word FIFO
//
// Ports:
//   pclk, presetn     rising-edge clock, asynchronous active-low reset
//   paddr..pwdata     APB4 slave inputs; register offset taken from paddr[5:2]
//   prdata            read data, 0 outside read handshakes and while in reset
//   pready            tied high (zero wait states)
//   pslverr           config write while busy, or DATA write into a full FIFO
//   irq_o             one-cycle completion pulse (busy -> done) when CTRL.ie set
//
// Build option: define APB4_CRC_PROG_IRQ_EN to implement irq_o and CTRL.ie;
// without it irq_o is 0 and CTRL[8] reads 0.
module apb4_crc_prog #(
    parameter int FIFO_DEPTH    = 4,
    parameter int CRC_MAX_WIDTH = 32
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef APB4_CRC_PROG_IRQ_EN
    localparam logic [8:0] CTRL_WMASK = 9'h17F;
`else
    localparam logic [8:0] CTRL_WMASK = 9'h07F;
`endif

    typedef enum logic {IDLE, CALC} state_e;

    logic [8:0]               ctrl_q;
    logic [CRC_MAX_WIDTH-1:0] poly_q, init_q, xorv_q, crc_q, crc_d;
    logic [33:0]              fifo_q [FIFO_DEPTH];
    logic [AW-1:0]            wptr_q, rptr_q;
    logic [AW:0]              cnt_q;
    logic                     ovf_q;
    state_e                   state_q, state_d;
    logic [31:0]              shift_q, shift_d;
    logic [2:0]               bcnt_q, bcnt_d;

    logic        en, revin, revout;
    logic [1:0]  wsel, dsize;
    logic [31:0] mask, crc_rev, res, stat, rdata;
    logic [33:0] head;
    logic [7:0]  din;
    logic [3:0]  off;
    logic        wr, rd, empty, full, done, busy;
    logic        clr_wr, cfg_wr, cfg_ok, ctrl_we, data_wr, push, pop;
    logic        unused;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = b[31-i];
        return r;
    endfunction

    // Bit-serial MSB-first update of one byte; the feedback tap follows the active width
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d,
                                             input logic [31:0] p, input logic [31:0] m,
                                             input logic [1:0] ws);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = (ws == 2'd0 ? r[7] : ws == 2'd1 ? r[15] : r[31]) ^ d[i];
            r  = ((r << 1) & m) ^ (fb ? p & m : 32'd0);
        end
        return r;
    endfunction

    assign en     = ctrl_q[0];
    assign revin  = ctrl_q[1];
    assign revout = ctrl_q[2];
    assign wsel   = ctrl_q[4:3];
    assign dsize  = ctrl_q[6:5];
    assign mask   = wsel == 2'd0 ? 32'h0000_00FF : wsel == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    assign off    = paddr[5:2];
    assign wr     = psel & penable & pwrite;
    assign rd     = psel & penable & ~pwrite;
    assign unused = ^{paddr[31:6], paddr[1:0]};

    assign empty  = cnt_q == '0;
    assign full   = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign done   = empty & (state_q == IDLE) & en;
    assign busy   = ~done & en;

    // clr is honoured even while busy; every other config write needs an idle engine
    assign clr_wr  = wr & (off == 4'd0) & pwdata[7];
    assign cfg_wr  = wr & (((off == 4'd0) & ~pwdata[7]) | (off == 4'd1) | (off == 4'd2) | (off == 4'd3));
    assign cfg_ok  = cfg_wr & ~busy;
    assign ctrl_we = clr_wr | (cfg_ok & (off == 4'd0));
    assign data_wr = wr & (off == 4'd4) & en;
    assign push    = data_wr & ~full;

    // Pop when idle, or on the last byte of a word so consecutive words run without a bubble
    assign head = fifo_q[rptr_q];
    assign pop  = ~clr_wr & ~empty & (state_q == IDLE || bcnt_q == 3'd1);
    assign din  = revin ? rev8(shift_q[31:24]) : shift_q[31:24];

    always_comb begin
        crc_d   = crc_q;
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        if (state_q == CALC) begin
            crc_d   = crc_byte(crc_q, din, poly_q, mask, wsel);
            shift_d = shift_q << 8;
            bcnt_d  = bcnt_q - 3'd1;
            state_d = bcnt_q == 3'd1 ? IDLE : CALC;
        end
        // Left-align the word so its first byte sits in shift_q[31:24]
        if (pop) begin
            state_d = CALC;
            shift_d = head[31:0] << {~head[33:32], 3'b000};
            bcnt_d  = {1'b0, head[33:32]} + 3'd1;
        end
        if (clr_wr || (ctrl_we && !en && pwdata[0]))
            crc_d = init_q;
        if (clr_wr)
            state_d = IDLE;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_q  <= '0;
            poly_q  <= '0;
            init_q  <= '0;
            xorv_q  <= '0;
            crc_q   <= '0;
            state_q <= IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (ctrl_we)
                ctrl_q <= pwdata[8:0] & CTRL_WMASK;
            if (cfg_ok && off == 4'd1)
                poly_q <= pwdata;
            if (cfg_ok && off == 4'd2)
                init_q <= pwdata;
            if (cfg_ok && off == 4'd3)
                xorv_q <= pwdata;
            crc_q   <= crc_d;
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            if (clr_wr) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (push)
                    wptr_q <= wptr_q + AW'(1);
                if (pop)
                    rptr_q <= rptr_q + AW'(1);
                cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
                if (data_wr && full)
                    ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (push)
            fifo_q[wptr_q] <= {dsize, pwdata};
    end

    assign crc_rev = rev32(crc_q) >> (wsel == 2'd0 ? 5'd24 : wsel == 2'd1 ? 5'd16 : 5'd0);
    assign res     = ((revout ? crc_rev : crc_q) ^ xorv_q) & mask;
    assign stat    = {19'd0, 5'(cnt_q), 3'd0, ovf_q, empty, full, busy, done};

    always_comb begin
        rdata = off == 4'd0 ? {23'd0, ctrl_q} :
                off == 4'd1 ? poly_q :
                off == 4'd2 ? init_q :
                off == 4'd3 ? xorv_q :
                off == 4'd5 ? res :
                off == 4'd6 ? stat : 32'd0;
    end

    assign prdata  = (presetn && rd) ? rdata : 32'd0;
    assign pready  = 1'b1;
    assign pslverr = presetn & wr & ((cfg_wr & busy) | (data_wr & full));

`ifdef APB4_CRC_PROG_IRQ_EN
    logic busy_q, irq_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            busy_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            busy_q <= busy;
            irq_q  <= ctrl_q[8] & busy_q & done;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_crc_prog.sv
// tb_apb4_crc_prog: scoreboard bench for apb4_crc_prog (CRC-32/16/8, overflow, busy, reset)
module tb_apb4_crc_prog;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_CTRL = 32'h00, A_POLY = 32'h04, A_INIT = 32'h08, A_XORV = 32'h0C;
    localparam logic [31:0] A_DATA = 32'h10, A_RES = 32'h14, A_STAT = 32'h18;
`ifdef APB4_CRC_PROG_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h117;
    localparam logic [31:0] IRQ_EXP = 32'd1;
`else
    localparam logic [31:0] CTRL_RB = 32'h017;
    localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    typedef logic [7:0] bq_t[$];

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr, irq_o;
    logic        last_err;
    int          n_chk = 0, n_fail = 0, irq_cnt = 0;
    exp_t        sb[$];

    apb4_crc_prog #(.FIFO_DEPTH(DEPTH), .CRC_MAX_WIDTH(32)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (irq_o) irq_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge; one transfer every two cycles
    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        psel = 1'b1; pwrite = w; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk); r = prdata; e = pslverr;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
        logic [31:0] r;
        apb(1'b1, a, d, r, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apb_wr(a, d, last_err);
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] v);
        logic e;
        apb(1'b0, a, 32'd0, v, e);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t x;
        x.tag = tag;
        x.val = v;
        sb.push_back(x);
    endtask

    task automatic check_res();
        logic [31:0] v;
        exp_t x;
        apb_rd(A_RES, v);
        if (sb.size() == 0) check("scoreboard underflow", 32'd1, 32'd0);
        else begin
            x = sb.pop_front();
            check(x.tag, v, x.val);
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 200 && !s[0]; i++) apb_rd(A_STAT, s);
        check({tag, " done"}, {31'd0, s[0]}, 32'd1);
    endtask

    // Reference: plain MSB-first CRC of width w over a byte stream, no reflection
    function automatic logic [31:0] ref_crc(input bq_t b, input logic [31:0] init,
                                            input logic [31:0] poly, input logic [31:0] xorv,
                                            input int w);
        logic [31:0] m, c;
        logic        top;
        m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        c = init & m;
        foreach (b[k]) begin
            for (int j = 7; j >= 0; j--) begin
                top = c[w-1];
                c = (c << 1) & m;
                if (top ^ b[k][j]) c = c ^ (poly & m);
            end
        end
        return (c ^ xorv) & m;
    endfunction

    initial begin
        logic [31:0] v, s, c0;
        logic [31:0] words[DEPTH+2];
        logic        e, eacc;
        bq_t         msg, acc;

        for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));

        // Reset: outputs quiet even with a read in progress
        presetn = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_STAT; pwdata = 32'd0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst prdata", prdata, 32'd0);
        check("rst pslverr", 32'(pslverr), 32'd0);
        check("rst irq", 32'(irq_o), 32'd0);
        check("pready", 32'(pready), 32'd1);
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        @(posedge pclk); #1;
        apb_rd(A_CTRL, v); check("rst ctrl", v, 32'd0);
        apb_rd(A_POLY, v); check("rst poly", v, 32'd0);
        apb_rd(A_STAT, v); check("rst stat", v, 32'h8);
        wr(32'h1C, 32'hFFFF_FFFF);
        apb_rd(32'h1C, v); check("unmapped rd", v, 32'd0);
        apb_rd(A_DATA, v); check("data rd", v, 32'd0);

        // CRC-32 (reflected) over "123456789"
        wr(A_POLY, 32'h04C1_1DB7); wr(A_INIT, 32'hFFFF_FFFF); wr(A_XORV, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h197);
        apb_rd(A_CTRL, v); check("ctrl readback", v, CTRL_RB);
        eacc = 1'b0;
        foreach (msg[i]) begin
            apb_wr(A_DATA, {24'd0, msg[i]}, e);
            eacc |= e;
        end
        push_exp("crc32 res", 32'hCBF4_3926);
        check("crc32 pslverr", 32'(eacc), 32'd0);
        wait_done("crc32");
        check_res();

        // CRC-16/CCITT-FALSE: two 4-byte words then one single-byte word
        wr(A_POLY, 32'h1021); wr(A_INIT, 32'hFFFF); wr(A_XORV, 32'd0);
        wr(A_CTRL, 32'hE9);
        wr(A_DATA, 32'h3132_3334); wr(A_DATA, 32'h3536_3738);
        wait_done("crc16 words");
        wr(A_CTRL, 32'h09);
        wr(A_DATA, 32'h39);
        push_exp("crc16 res", 32'h29B1);
        wait_done("crc16");
        check_res();

        // CRC-8 with interrupt enable
        wr(A_POLY, 32'h07); wr(A_INIT, 32'd0); wr(A_XORV, 32'd0);
        wr(A_CTRL, 32'h181);
        c0 = irq_cnt;
        foreach (msg[i]) wr(A_DATA, {24'd0, msg[i]});
        push_exp("crc8 res", 32'hF4);
        wait_done("crc8");
        check_res();
        repeat (3) @(posedge pclk);
        #1;
        check("crc8 irq pulses", irq_cnt - c0, IRQ_EXP);

        // Overflow: one write per cycle while the engine needs four cycles per word
        wr(A_POLY, 32'h1021); wr(A_INIT, 32'hFFFF); wr(A_XORV, 32'h0F0F);
        wr(A_CTRL, 32'hE9);
        foreach (words[i]) words[i] = $urandom;
        psel = 1'b1; pwrite = 1'b1; paddr = A_DATA; pwdata = words[0]; penable = 1'b0;
        @(posedge pclk); #1 penable = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            pwdata = words[i];
            @(negedge pclk);
            check($sformatf("ovf pslverr %0d", i), 32'(pslverr), 32'(i == DEPTH + 1));
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            for (int j = 3; j >= 0; j--) acc.push_back(words[i][8*j +: 8]);
        push_exp("ovf res", ref_crc(acc, 32'hFFFF, 32'h1021, 32'h0F0F, 16));
        wait_done("ovf");
        apb_rd(A_STAT, s); check("ovf flag", 32'(s[4]), 32'd1);
        check_res();
        wr(A_CTRL, 32'hE9);
        apb_rd(A_STAT, s);
        check("clr ovf", 32'(s[4]), 32'd0);
        check("clr count", 32'(s[12:8]), 32'd0);
        push_exp("clr res", 32'hF0F0);
        check_res();

        // Config write while busy is rejected
        wr(A_DATA, 32'hA5A5_A5A5);
        apb_wr(A_POLY, 32'hDEAD, e);
        check("busy pslverr", 32'(e), 32'd1);
        wait_done("busy");
        apb_rd(A_POLY, v); check("busy poly kept", v, 32'h1021);

        // Reset in the middle of a word
        wr(A_DATA, 32'h1234_5678);
        @(posedge pclk); #2;
        presetn = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_STAT;
        #2;
        check("midrst prdata", prdata, 32'd0);
        check("midrst irq", 32'(irq_o), 32'd0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        @(posedge pclk); #1;
        apb_rd(A_CTRL, v); check("post rst ctrl", v, 32'd0);
        apb_rd(A_POLY, v); check("post rst poly", v, 32'd0);
        apb_rd(A_INIT, v); check("post rst init", v, 32'd0);
        apb_rd(A_XORV, v); check("post rst xorv", v, 32'd0);
        apb_rd(A_RES, v); check("post rst res", v, 32'd0);
        apb_rd(A_STAT, v); check("post rst stat", v, 32'h8);
        check("post rst irq", 32'(irq_o), 32'd0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
